// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-fetch requester, the data requester, the single
// memory port and the pipeline stall outputs of mem_arbiter.
//   slave  : arbiter view (requests and memory responses in, strobes/bus out)
//   master : environment view (requesters + memory drive, observe the rest)
// Parameters: ADDR_W address width, DATA_W data width.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // instruction fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  // data requester
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  // shared memory port
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  // pipeline stalls
  logic              stall_if_o;
  logic              stall_d_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rvalid_o, if_rdata_o,
    output d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_d_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rvalid_o, if_rdata_o,
    input  d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_d_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between instruction fetch and the data path, one
// outstanding transaction at a time. Data has priority, but after
// MAX_D_BURST consecutive data grants taken while fetch was waiting, fetch
// wins the next arbitration.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    mem_arbiter_if.slave: requesters, memory port, stalls
// Parameters: ADDR_W, DATA_W, MAX_D_BURST (>= 1).
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MAX_D_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] DCNT_MAX = CNT_W'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;

  logic burst_full;
  logic d_wins;
  logic rsp_fire;

  assign burst_full = (dcnt_q == DCNT_MAX);
  // Data wins unless fetch is waiting and data has used up its burst.
  assign d_wins     = bus.d_req_i && !(bus.if_req_i && burst_full);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          owner_d = OWN_D;
          we_d    = bus.d_we_i;
          addr_d  = bus.d_addr_i;
          wdata_d = bus.d_wdata_i;
          // Count only grants that made fetch wait; saturate for safety.
          if (bus.if_req_i) begin
            dcnt_d = burst_full ? dcnt_q : dcnt_q + CNT_W'(1);
          end else begin
            dcnt_d = '0;
          end
          state_d = REQ;
        end else if (bus.if_req_i) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr_i;
          wdata_d = '0;
          dcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A response arriving while reset is asserted belongs to an abandoned
  // transaction, so it is not forwarded to the requester.
  assign rsp_fire = (state_q == RSP) && bus.mem_rvalid_i && !rst_i;

  assign bus.if_rvalid_o = rsp_fire && (owner_q == OWN_IF);
  assign bus.d_rvalid_o  = rsp_fire && (owner_q == OWN_D);
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.d_rdata_o   = bus.mem_rdata_i;

  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  assign bus.stall_if_o  = bus.if_req_i && !bus.if_rvalid_o;
  assign bus.stall_d_o   = bus.d_req_i && !bus.d_rvalid_o;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(4)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // memory model controls
  int            gnt_delay = 0;
  int            rsp_delay = 0;
  logic          stray_rv  = 1'b0;
  logic          resp_rv   = 1'b0;
  logic          req_s     = 1'b0;
  logic [AW-1:0] addr_s    = '0;

  assign bus.mem_rvalid_i = resp_rv | stray_rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hABCD;
    return {a[7:0], ~a[15:8]} ^ 16'h1357;
  endfunction

  task automatic push(input logic is_d, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    exp_t e;
    e.is_d  = is_d;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.rdata = rd_fn(a);
    exp_q.push_back(e);
  endtask

  // Memory responder: driven just after the rising edge.
  initial begin
    int   gcnt;
    int   rcnt;
    logic pending;
    logic [AW-1:0] lat_addr;
    gcnt = 0; rcnt = 0; pending = 1'b0; lat_addr = '0;
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        pending = 1'b0; gcnt = 0; rcnt = 0;
      end else if (pending && resp_rv) begin
        pending = 1'b0;
      end else if (req_s && bus.mem_gnt_i) begin
        pending = 1'b1; rcnt = 0; gcnt = 0; lat_addr = addr_s;
      end
      resp_rv       = 1'b0;
      bus.mem_gnt_i = 1'b0;
      if (rst_i) begin
        gcnt = 0;
      end else if (pending) begin
        if (rcnt >= rsp_delay) resp_rv = 1'b1;
        else rcnt++;
      end else if (bus.mem_req_o) begin
        if (gcnt >= gnt_delay) bus.mem_gnt_i = 1'b1;
        else gcnt++;
      end else begin
        gcnt = 0;
      end
      bus.mem_rdata_i = resp_rv ? rd_fn(lat_addr) : DW'($urandom);
    end
  end

  // Scoreboard monitor: grant fields and completions, sampled on falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      req_s  = bus.mem_req_o;
      addr_s = bus.mem_addr_o;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 1, 0);
        end else begin
          chk("grant_addr", bus.mem_addr_o, exp_q[0].addr);
          chk("grant_we", bus.mem_we_o, exp_q[0].we);
          if (exp_q[0].we) chk("grant_wdata", bus.mem_wdata_o, exp_q[0].wdata);
        end
      end
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        chk("rvalid_both", bus.if_rvalid_o & bus.d_rvalid_o, 0);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", bus.d_rvalid_o, e.is_d);
          if (!e.we) chk("rvalid_rdata", e.is_d ? bus.d_rdata_o : bus.if_rdata_o, e.rdata);
          $display("txn %s %s addr=0x%04h data=0x%04h", e.is_d ? "D " : "IF",
                   e.we ? "st" : "ld", e.addr,
                   e.we ? e.wdata : (e.is_d ? bus.d_rdata_o : bus.if_rdata_o));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Single fetch with immediate memory; call at falling edge + 1 with DUT idle.
  task automatic do_fetch(input logic [AW-1:0] a, input string tag);
    push(1'b0, 1'b0, a, '0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    #1;
    chk({tag, "_stall_c0"}, bus.stall_if_o, 1);
    @(negedge clk);
    chk({tag, "_req_c1"}, bus.mem_req_o, 1);
    chk({tag, "_addr_c1"}, bus.mem_addr_o, a);
    chk({tag, "_stall_c1"}, bus.stall_if_o, 1);
    chk({tag, "_no_rvalid_c1"}, bus.if_rvalid_o, 0);
    @(negedge clk);
    chk({tag, "_rvalid_c2"}, bus.if_rvalid_o, 1);
    chk({tag, "_rdata_c2"}, bus.if_rdata_o, rd_fn(a));
    chk({tag, "_stall_c2"}, bus.stall_if_o, 0);
    chk({tag, "_req_c2"}, bus.mem_req_o, 0);
    #1;
    bus.if_req_i = 1'b0;
  endtask

  int   d_n, if_n, d_at_if1, d_at_if2;
  logic dv, iv, seen_req, d_first, d_done, if_done;

  initial begin
    rst_i         = 1'b1;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_d_rvalid", bus.d_rvalid_o, 0);
    chk("rst_stall_d", bus.stall_d_o, 1);
    chk("rst_stall_if", bus.stall_if_o, 0);
    #1;
    bus.d_req_i = 1'b0;
    rst_i       = 1'b0;
    @(negedge clk);
    #1;

    // ---- single fetch ----
    do_fetch(16'h0010, "fetch");

    // ---- priority: IF and D together ----
    @(negedge clk);
    #1;
    push(1'b1, 1'b0, 16'h0200, '0);
    push(1'b0, 1'b0, 16'h0300, '0);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 16'h0200;
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0300;
    seen_req = 1'b0; d_first = 1'b0; d_done = 1'b0; if_done = 1'b0;
    for (int c = 0; c < 30 && !(d_done && if_done); c++) begin
      @(negedge clk);
      dv = bus.d_rvalid_o; iv = bus.if_rvalid_o;
      if (bus.mem_req_o && !seen_req) begin
        seen_req = 1'b1;
        chk("prio_first_addr", bus.mem_addr_o, 16'h0200);
      end
      if (dv && !if_done) d_first = 1'b1;
      #1;
      if (dv) begin d_done = 1'b1; bus.d_req_i = 1'b0; end
      if (iv) begin if_done = 1'b1; bus.if_req_i = 1'b0; end
    end
    chk("prio_d_first", d_first, 1);
    chk("prio_both_done", d_done & if_done, 1);

    // ---- starvation bound: IF held, back-to-back D loads ----
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 16'h0400 + 16'(k), '0);
    push(1'b0, 1'b0, 16'h0100, '0);
    for (int k = 4; k < 8; k++) push(1'b1, 1'b0, 16'h0400 + 16'(k), '0);
    push(1'b0, 1'b0, 16'h0180, '0);
    push(1'b1, 1'b0, 16'h0408, '0);
    d_n = 0; if_n = 0; d_at_if1 = -1; d_at_if2 = -1;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 16'h0400;
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0100;
    for (int c = 0; c < 100 && (d_n < 9 || if_n < 2); c++) begin
      @(negedge clk);
      dv = bus.d_rvalid_o; iv = bus.if_rvalid_o;
      if (dv) d_n++;
      if (iv) begin
        if_n++;
        if (if_n == 1) d_at_if1 = d_n;
        if (if_n == 2) d_at_if2 = d_n;
      end
      #1;
      if (dv) begin
        if (d_n < 9) bus.d_addr_i = 16'h0400 + 16'(d_n);
        else bus.d_req_i = 1'b0;
      end
      if (iv) begin
        if (if_n == 1) bus.if_addr_i = 16'h0180;
        else bus.if_req_i = 1'b0;
      end
    end
    chk("burst_d_before_if1", d_at_if1, 4);
    chk("burst_d_before_if2", d_at_if2, 8);
    chk("burst_d_total", d_n, 9);
    chk("burst_if_total", if_n, 2);
    chk("burst_q_empty", exp_q.size(), 0);

    // ---- back-pressure store ----
    @(negedge clk);
    #1;
    gnt_delay = 3; rsp_delay = 1;
    push(1'b1, 1'b1, 16'h0040, 16'h1234);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 16'h0040; bus.d_wdata_i = 16'h1234;
    #1;
    chk("bp_stall_c0", bus.stall_d_o, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("bp_req_held", bus.mem_req_o, 1);
      chk("bp_we_held", bus.mem_we_o, 1);
      chk("bp_addr_held", bus.mem_addr_o, 16'h0040);
      chk("bp_wdata_held", bus.mem_wdata_o, 16'h1234);
      chk("bp_no_early_ack", bus.d_rvalid_o, 0);
      if (c == 2) begin #1; bus.d_addr_i = 16'hFFFF; end
    end
    @(negedge clk);
    chk("bp_req_dropped", bus.mem_req_o, 0);
    chk("bp_ack_wait", bus.d_rvalid_o, 0);
    @(negedge clk);
    chk("bp_ack", bus.d_rvalid_o, 1);
    chk("bp_stall_end", bus.stall_d_o, 0);
    #1;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    gnt_delay = 0; rsp_delay = 0;

    // ---- reset while in RSP ----
    @(negedge clk);
    #1;
    rsp_delay = 5;
    push(1'b0, 1'b0, 16'h0777, '0);
    bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0777;
    @(negedge clk);
    chk("rstmid_req_c1", bus.mem_req_o, 1);
    @(negedge clk);
    chk("rstmid_in_rsp", bus.mem_req_o, 0);
    #1;
    rst_i = 1'b1; stray_rv = 1'b1; bus.if_req_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstmid_req", bus.mem_req_o, 0);
    chk("rstmid_if_rvalid", bus.if_rvalid_o, 0);
    chk("rstmid_d_rvalid", bus.d_rvalid_o, 0);
    #1;
    rst_i = 1'b0; stray_rv = 1'b0; rsp_delay = 0;
    @(negedge clk);
    #1;
    do_fetch(16'h0321, "post_rst");

    // ---- stray response while idle ----
    @(negedge clk);
    #1;
    stray_rv = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_if_rvalid", bus.if_rvalid_o, 0);
      chk("stray_d_rvalid", bus.d_rvalid_o, 0);
      chk("stray_req", bus.mem_req_o, 0);
    end
    #1;
    stray_rv = 1'b0;
    @(negedge clk);
    #1;
    do_fetch(16'h0555, "after_stray");

    @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
